sim_mem_fuzz_lane_arbiter: RTL and testbench

//  Schedules per-lane memory requests from the simulation fuzzer/trace source onto one memory port.

---
 rtl/sim_mem_fuzz_lane_arbiter.sv | 138 +++++++++++++
 tb/tb_sim_mem_fuzz_lane_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_fuzz_lane_arbiter.sv
// Per-lane request batch buffer drained round-robin onto a single memory port.
// Issue is limited by an outstanding-request cap, and a sticky done flag is raised once the source is finished and all traffic has retired.
module sim_mem_fuzz_lane_arbiter #(
  parameter int NUM_LANES       = 4,
  parameter int DATA_W          = 64,
  parameter int LOGSIZE_W       = 8,
  parameter int MAX_OUTSTANDING = 8,
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           in_ready,
  input  logic [NUM_LANES-1:0]           in_valid,
  input  logic [DATA_W*NUM_LANES-1:0]    in_address,
  input  logic [NUM_LANES-1:0]           in_is_store,
  input  logic [LOGSIZE_W*NUM_LANES-1:0] in_size,
  input  logic [DATA_W*NUM_LANES-1:0]    in_data,
  input  logic                           in_finished,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANE_W-1:0]              out_lane,
  output logic [DATA_W-1:0]              out_address,
  output logic                           out_is_store,
  output logic [LOGSIZE_W-1:0]           out_size,
  output logic [DATA_W-1:0]              out_data,
  input  logic                           resp_valid,
  output logic [CNT_W-1:0]               outstanding,
  output logic                           done,
  output logic                           err_underflow
);

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                 state, state_next;
  logic [NUM_LANES-1:0]   buf_valid;
  logic [DATA_W-1:0]      buf_address [NUM_LANES];
  logic                   buf_is_store [NUM_LANES];
  logic [LOGSIZE_W-1:0]   buf_size [NUM_LANES];
  logic [DATA_W-1:0]      buf_data [NUM_LANES];
  logic [LANE_W-1:0]      rr_ptr, grant, rr_next;
  logic                   found, fire, last_pending;
  int                     lane_idx;

  // Grant is the first pending lane at or after rr_ptr, wrapping around
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    lane_idx = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_idx = (int'(rr_ptr) + i) % NUM_LANES;
      if (!found && buf_valid[lane_idx]) begin
        found = 1'b1;
        grant = LANE_W'(lane_idx);
      end
    end
  end

  assign rr_next      = (int'(grant) == NUM_LANES - 1) ? '0 : grant + 1'b1;
  assign last_pending = (buf_valid & ~(NUM_LANES'(1) << grant)) == '0;
  assign fire         = out_valid && out_ready;

  always_comb begin
    state_next   = state;
    in_ready     = (state == S_LOAD);
    done         = (state == S_DONE);
    out_valid    = (state == S_DRAIN) && found && (outstanding < CNT_W'(MAX_OUTSTANDING));
    out_lane     = '0;
    out_address  = '0;
    out_is_store = 1'b0;
    out_size     = '0;
    out_data     = '0;
    if (out_valid) begin
      out_lane     = grant;
      out_address  = buf_address[grant];
      out_is_store = buf_is_store[grant];
      out_size     = buf_size[grant];
      out_data     = buf_data[grant];
    end
    case (state)
      S_LOAD: begin
        if (in_finished)    state_next = S_FLUSH;
        else if (|in_valid) state_next = S_DRAIN;
      end
      S_DRAIN: if (fire && last_pending) state_next = S_LOAD;
      S_FLUSH: if (outstanding == '0) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_next;
  end

  // Batch capture in LOAD; a fire retires the granted buffer and moves rr_ptr past it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      for (int g = 0; g < NUM_LANES; g++) begin
        buf_address[g]  <= '0;
        buf_is_store[g] <= 1'b0;
        buf_size[g]     <= '0;
        buf_data[g]     <= '0;
      end
    end else if (state == S_LOAD && !in_finished && |in_valid) begin
      buf_valid <= in_valid;
      for (int g = 0; g < NUM_LANES; g++) begin
        buf_address[g]  <= in_address[DATA_W*g +: DATA_W];
        buf_is_store[g] <= in_is_store[g];
        buf_size[g]     <= in_size[LOGSIZE_W*g +: LOGSIZE_W];
        buf_data[g]     <= in_data[DATA_W*g +: DATA_W];
      end
    end else if (fire) begin
      buf_valid[grant] <= 1'b0;
      rr_ptr           <= rr_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({fire, resp_valid})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) err_underflow <= 1'b1;
          else                   outstanding   <= outstanding - 1'b1;
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_mem_fuzz_lane_arbiter.sv
// Directed bench for sim_mem_fuzz_lane_arbiter: ordering, round-robin carry-over, stall, cap, flush/done and reset.
module tb_sim_mem_fuzz_lane_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   in_valid, c_in_valid;
  logic [255:0] in_address, in_data;
  logic [3:0]   in_is_store;
  logic [31:0]  in_size;
  logic         in_finished, c_in_finished;
  logic         out_ready, c_out_ready;
  logic         resp_valid, c_resp_valid;

  logic         in_ready, out_valid, out_is_store, done, err_underflow;
  logic [1:0]   out_lane;
  logic [63:0]  out_address, out_data;
  logic [7:0]   out_size;
  logic [3:0]   outstanding;

  logic         c_in_ready, c_out_valid, c_out_is_store, c_done, c_err_underflow;
  logic [1:0]   c_out_lane;
  logic [63:0]  c_out_address, c_out_data;
  logic [7:0]   c_out_size;
  logic [1:0]   c_outstanding;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sim_mem_fuzz_lane_arbiter dut (
    .clock(clock), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_address(in_address), .in_is_store(in_is_store), .in_size(in_size),
    .in_data(in_data), .in_finished(in_finished), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane(out_lane), .out_address(out_address),
    .out_is_store(out_is_store), .out_size(out_size), .out_data(out_data),
    .resp_valid(resp_valid), .outstanding(outstanding), .done(done),
    .err_underflow(err_underflow)
  );

  sim_mem_fuzz_lane_arbiter #(.MAX_OUTSTANDING(2)) dut_cap (
    .clock(clock), .reset(reset), .in_ready(c_in_ready), .in_valid(c_in_valid),
    .in_address(in_address), .in_is_store(in_is_store), .in_size(in_size),
    .in_data(in_data), .in_finished(c_in_finished), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_lane(c_out_lane), .out_address(c_out_address),
    .out_is_store(c_out_is_store), .out_size(c_out_size), .out_data(c_out_data),
    .resp_valid(c_resp_valid), .outstanding(c_outstanding), .done(c_done),
    .err_underflow(c_err_underflow)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int order_a [4];
    int order_b [4];
    order_a = '{0, 1, 2, 3};
    order_b = '{2, 3, 0, 1};

    reset = 1'b1;
    in_valid = '0; in_finished = 1'b0; out_ready = 1'b0; resp_valid = 1'b0;
    c_in_valid = '0; c_in_finished = 1'b0; c_out_ready = 1'b0; c_resp_valid = 1'b0;
    for (int g = 0; g < 4; g++) begin
      in_address[64*g +: 64] = 64'hA000 + 64'(g);
      in_data[64*g +: 64]    = 64'hD000 + 64'(g);
      in_size[8*g +: 8]      = 8'(g);
      in_is_store[g]         = (g % 2) == 1;
    end
    #2;
    check_output("rst_in_ready", 64'(in_ready), 1);
    check_output("rst_out_valid", 64'(out_valid), 0);
    check_output("rst_out_lane", 64'(out_lane), 0);
    check_output("rst_out_address", out_address, 0);
    check_output("rst_done", 64'(done), 0);
    check_output("rst_err", 64'(err_underflow), 0);
    check_output("rst_outstanding", 64'(outstanding), 0);
    step();
    reset = 1'b0;
    step();

    // Sparse batch: lanes 0,2,3 in order, then back to LOAD
    in_valid = 4'b1101; out_ready = 1'b1;
    #1;
    check_output("t1_in_ready_accept", 64'(in_ready), 1);
    step();
    in_valid = '0;
    #1;
    check_output("t1_c1_valid", 64'(out_valid), 1);
    check_output("t1_c1_lane", 64'(out_lane), 0);
    check_output("t1_c1_addr", out_address, 64'hA000);
    check_output("t1_c1_in_ready", 64'(in_ready), 0);
    step();
    check_output("t1_c2_lane", 64'(out_lane), 2);
    check_output("t1_c2_addr", out_address, 64'hA002);
    check_output("t1_c2_store", 64'(out_is_store), 0);
    step();
    check_output("t1_c3_lane", 64'(out_lane), 3);
    check_output("t1_c3_data", out_data, 64'hD003);
    check_output("t1_c3_size", 64'(out_size), 3);
    check_output("t1_c3_store", 64'(out_is_store), 1);
    step();
    check_output("t1_c4_in_ready", 64'(in_ready), 1);
    check_output("t1_c4_out_valid", 64'(out_valid), 0);
    check_output("t1_c4_outstanding", 64'(outstanding), 3);

    // Full batch with rr_ptr back at 0
    in_valid = 4'b1111;
    step();
    in_valid = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("t2a_lane%0d", k), 64'(out_lane), 64'(order_a[k]));
      check_output($sformatf("t2a_valid%0d", k), 64'(out_valid), 1);
      step();
    end
    check_output("t2a_outstanding", 64'(outstanding), 7);
    resp_valid = 1'b1;
    repeat (7) step();
    resp_valid = 1'b0;
    #1;
    check_output("t2_retired", 64'(outstanding), 0);
    check_output("t2_no_err", 64'(err_underflow), 0);

    // Lane 1 alone leaves rr_ptr at 2 for the next batch
    in_valid = 4'b0010;
    step();
    in_valid = '0;
    #1;
    check_output("t2_pre_lane", 64'(out_lane), 1);
    step();
    check_output("t2_pre_in_ready", 64'(in_ready), 1);
    in_valid = 4'b1111;
    step();
    in_valid = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("t2b_lane%0d", k), 64'(out_lane), 64'(order_b[k]));
      step();
    end
    check_output("t2b_outstanding", 64'(outstanding), 5);

    // Stalled lane-1 request must hold steady
    out_ready = 1'b0;
    in_valid = 4'b0010;
    step();
    in_valid = '0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("t4_valid%0d", k), 64'(out_valid), 1);
      check_output($sformatf("t4_lane%0d", k), 64'(out_lane), 1);
      check_output($sformatf("t4_addr%0d", k), out_address, 64'hA001);
      check_output($sformatf("t4_data%0d", k), out_data, 64'hD001);
      check_output($sformatf("t4_size%0d", k), 64'(out_size), 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    step();
    check_output("t4_outstanding", 64'(outstanding), 6);
    check_output("t4_in_ready", 64'(in_ready), 1);
    resp_valid = 1'b1;
    repeat (3) step();
    resp_valid = 1'b0;
    #1;
    check_output("t5_pre_outstanding", 64'(outstanding), 3);

    // Finish with traffic in flight; same-cycle in_valid is ignored
    in_finished = 1'b1; in_valid = 4'b0001;
    step();
    in_finished = 1'b0; in_valid = '0;
    #1;
    check_output("t5_flush_in_ready", 64'(in_ready), 0);
    check_output("t5_flush_out_valid", 64'(out_valid), 0);
    check_output("t5_flush_done", 64'(done), 0);
    check_output("t5_flush_outstanding", 64'(outstanding), 3);
    resp_valid = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      step();
      check_output($sformatf("t5_drain%0d", k), 64'(outstanding), 64'(k));
    end
    resp_valid = 1'b0;
    step();
    check_output("t5_done", 64'(done), 1);
    step();
    step();
    check_output("t5_done_sticky", 64'(done), 1);
    check_output("t5_done_in_ready", 64'(in_ready), 0);
    check_output("t5_done_out_valid", 64'(out_valid), 0);
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    #1;
    check_output("t5_err", 64'(err_underflow), 1);
    check_output("t5_err_outstanding", 64'(outstanding), 0);
    check_output("t5_err_done", 64'(done), 1);

    // Reset clears sticky state
    reset = 1'b1;
    #1;
    check_output("t6_rst_done", 64'(done), 0);
    check_output("t6_rst_err", 64'(err_underflow), 0);
    check_output("t6_rst_in_ready", 64'(in_ready), 1);
    reset = 1'b0;
    step();

    // Reset in the middle of a drain with two lanes pending
    in_valid = 4'b0111; out_ready = 1'b1;
    step();
    in_valid = '0;
    #1;
    check_output("t6_first_lane", 64'(out_lane), 0);
    step();
    out_ready = 1'b0;
    #1;
    check_output("t6_pending_valid", 64'(out_valid), 1);
    check_output("t6_pending_lane", 64'(out_lane), 1);
    check_output("t6_pending_outstanding", 64'(outstanding), 1);
    reset = 1'b1;
    #1;
    check_output("t6_mid_out_valid", 64'(out_valid), 0);
    check_output("t6_mid_in_ready", 64'(in_ready), 1);
    check_output("t6_mid_outstanding", 64'(outstanding), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    check_output("t6_post_out_valid", 64'(out_valid), 0);
    check_output("t6_post_in_ready", 64'(in_ready), 1);
    step();
    check_output("t6_post2_out_valid", 64'(out_valid), 0);
    in_valid = 4'b0100;
    step();
    in_valid = '0;
    #1;
    check_output("t6_new_lane", 64'(out_lane), 2);
    check_output("t6_new_addr", out_address, 64'hA002);
    step();
    check_output("t6_new_outstanding", 64'(outstanding), 1);
    check_output("t6_new_in_ready", 64'(in_ready), 1);

    // Outstanding cap of 2 on the second instance
    c_in_valid = 4'b1111; c_out_ready = 1'b1;
    step();
    c_in_valid = '0;
    #1;
    check_output("t3_lane0", 64'(c_out_lane), 0);
    check_output("t3_valid0", 64'(c_out_valid), 1);
    step();
    check_output("t3_lane1", 64'(c_out_lane), 1);
    step();
    check_output("t3_cap_valid", 64'(c_out_valid), 0);
    check_output("t3_cap_outstanding", 64'(c_outstanding), 2);
    check_output("t3_cap_in_ready", 64'(c_in_ready), 0);
    step();
    check_output("t3_cap_hold", 64'(c_out_valid), 0);
    c_resp_valid = 1'b1;
    #1;
    check_output("t3_resp_same_cycle", 64'(c_out_valid), 0);
    step();
    check_output("t3_after_resp_cnt", 64'(c_outstanding), 1);
    check_output("t3_after_resp_valid", 64'(c_out_valid), 1);
    check_output("t3_after_resp_lane", 64'(c_out_lane), 2);
    step();
    check_output("t3_fire_resp_cnt", 64'(c_outstanding), 1);
    check_output("t3_fire_resp_lane", 64'(c_out_lane), 3);
    c_resp_valid = 1'b0;
    #1;
    step();
    check_output("t3_final_cnt", 64'(c_outstanding), 2);
    check_output("t3_final_valid", 64'(c_out_valid), 0);
    check_output("t3_final_in_ready", 64'(c_in_ready), 1);
    check_output("t3_no_err", 64'(c_err_underflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
